// File: rtl/cavlc_4x4_assembler.sv
// cavlc_4x4_assembler: collects a reverse-zigzag stream of 8-bit CAVLC
// coefficients into a 4x4 block and presents all 16 values in parallel.
// Define CAVLC_ASM_PINGPONG_EN for two alternating fill/present buffers;
// without it a single buffer is used.
// Handshakes: a transfer happens on a rising edge where valid && ready.
// coeff_ready_o depends on registered state only, and a presented block
// holds steady until it is consumed.
module cavlc_4x4_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       coeff_valid_i,
    output logic       coeff_ready_o,
    input  logic [7:0] coeff_i,
    input  logic       eob_i,
    output logic       blk_valid_o,
    input  logic       blk_ready_i,
    output logic [7:0] scale00_o, output logic [7:0] scale01_o,
    output logic [7:0] scale02_o, output logic [7:0] scale03_o,
    output logic [7:0] scale10_o, output logic [7:0] scale11_o,
    output logic [7:0] scale12_o, output logic [7:0] scale13_o,
    output logic [7:0] scale20_o, output logic [7:0] scale21_o,
    output logic [7:0] scale22_o, output logic [7:0] scale23_o,
    output logic [7:0] scale30_o, output logic [7:0] scale31_o,
    output logic [7:0] scale32_o, output logic [7:0] scale33_o
);
    typedef enum logic {FILLING = 1'b0, FULL = 1'b1} buf_state_e;

    // Two storage slots always exist. In single-buffer builds only slot 0
    // is ever written or presented.
    buf_state_e state_q [2];
    buf_state_e state_d [2];
    logic [15:0] mask_q [2];
    logic [15:0] mask_d [2];
    logic [7:0]  data_q [2][16];
    logic [3:0]  wr_idx_q, wr_idx_d;
    logic        pres_q, pres_d;
    logic        fill_sel;
    logic        accept, consume, complete;
    logic [3:0]  wr_pos;
    logic [7:0]  scale_w [16];

    // Reverse-zigzag write index to flattened position row*4+col.
    function automatic logic [3:0] pos_of(input logic [3:0] idx);
        case (idx)
            4'd0:    pos_of = 4'd15; 4'd1:  pos_of = 4'd14;
            4'd2:    pos_of = 4'd11; 4'd3:  pos_of = 4'd7;
            4'd4:    pos_of = 4'd10; 4'd5:  pos_of = 4'd13;
            4'd6:    pos_of = 4'd12; 4'd7:  pos_of = 4'd9;
            4'd8:    pos_of = 4'd6;  4'd9:  pos_of = 4'd3;
            4'd10:   pos_of = 4'd2;  4'd11: pos_of = 4'd5;
            4'd12:   pos_of = 4'd8;  4'd13: pos_of = 4'd4;
            4'd14:   pos_of = 4'd1;
            default: pos_of = 4'd0;
        endcase
    endfunction

`ifdef CAVLC_ASM_PINGPONG_EN
    assign fill_sel = ~pres_q;
`else
    assign fill_sel = 1'b0;
`endif

    assign wr_pos        = pos_of(wr_idx_q);
    assign coeff_ready_o = (state_q[fill_sel] != FULL);
    assign blk_valid_o   = (state_q[pres_q] == FULL);
    assign accept        = coeff_valid_i && coeff_ready_o;
    assign consume       = blk_valid_o && blk_ready_i;
    assign complete      = accept && (eob_i || (wr_idx_q == 4'd15));

    // Next-state: buffer states, written masks, write index, present slot.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        wr_idx_d = wr_idx_q;
        pres_d   = pres_q;
        if (consume) begin
            state_d[pres_q] = FILLING;
        end
        if (accept) begin
            mask_d[fill_sel] = ((wr_idx_q == 4'd0) ? 16'd0 : mask_q[fill_sel])
                               | (16'd1 << wr_pos);
            wr_idx_d = complete ? 4'd0 : (wr_idx_q + 4'd1);
            if (complete) begin
                state_d[fill_sel] = FULL;
            end
        end
`ifdef CAVLC_ASM_PINGPONG_EN
        // Swap when a freshly completed block can be shown right away, or
        // when a consumed block uncovers one that was already waiting.
        if (complete && ((state_q[pres_q] != FULL) || consume)) begin
            pres_d = fill_sel;
        end else if (consume && (state_q[fill_sel] == FULL)) begin
            pres_d = fill_sel;
        end
`endif
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= FILLING;
            state_q[1] <= FILLING;
            mask_q[0]  <= 16'd0;
            mask_q[1]  <= 16'd0;
            wr_idx_q   <= 4'd0;
            pres_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            wr_idx_q <= wr_idx_d;
            pres_q   <= pres_d;
        end
    end

    // Coefficient storage; the mask makes reset of the data unnecessary.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[fill_sel][wr_pos] <= coeff_i;
        end
    end

    // Unwritten positions of the presented block read as zero.
    always_comb begin
        for (int p = 0; p < 16; p++) begin
            scale_w[p] = mask_q[pres_q][p] ? data_q[pres_q][p] : 8'd0;
        end
    end

    assign scale00_o = scale_w[0];  assign scale01_o = scale_w[1];
    assign scale02_o = scale_w[2];  assign scale03_o = scale_w[3];
    assign scale10_o = scale_w[4];  assign scale11_o = scale_w[5];
    assign scale12_o = scale_w[6];  assign scale13_o = scale_w[7];
    assign scale20_o = scale_w[8];  assign scale21_o = scale_w[9];
    assign scale22_o = scale_w[10]; assign scale23_o = scale_w[11];
    assign scale30_o = scale_w[12]; assign scale31_o = scale_w[13];
    assign scale32_o = scale_w[14]; assign scale33_o = scale_w[15];
endmodule

// File: tb/tb_cavlc_4x4_assembler.sv
// Bench for cavlc_4x4_assembler: a zigzag reference model predicts each
// block, and a monitor compares presented blocks and handshake levels.
module tb_cavlc_4x4_assembler;
`ifdef CAVLC_ASM_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coeff_valid_i = 1'b0;
    logic       coeff_ready_o;
    logic [7:0] coeff_i = 8'd0;
    logic       eob_i = 1'b0;
    logic       blk_valid_o;
    logic       blk_ready_i = 1'b0;
    logic [7:0] s00, s01, s02, s03, s10, s11, s12, s13;
    logic [7:0] s20, s21, s22, s23, s30, s31, s32, s33;
    logic [127:0] dut_vec;

    int n_vec  = 0;
    int n_fail = 0;
    bit rand_ready = 1'b0;

    // Standard forward zigzag scan as flattened row*4+col positions.
    int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    logic [7:0]   part_q [$];
    logic [127:0] exp_q [$];

    cavlc_4x4_assembler dut (
        .clk(clk), .rst(rst),
        .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o),
        .coeff_i(coeff_i), .eob_i(eob_i),
        .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
        .scale00_o(s00), .scale01_o(s01), .scale02_o(s02), .scale03_o(s03),
        .scale10_o(s10), .scale11_o(s11), .scale12_o(s12), .scale13_o(s13),
        .scale20_o(s20), .scale21_o(s21), .scale22_o(s22), .scale23_o(s23),
        .scale30_o(s30), .scale31_o(s31), .scale32_o(s32), .scale33_o(s33)
    );

    assign dut_vec = {s33, s32, s31, s30, s23, s22, s21, s20,
                      s13, s12, s11, s10, s03, s02, s01, s00};

    // Clock
    always #5 clk = ~clk;

    // Reference model: the k-th coefficient of a block lands on the
    // (15-k)-th entry of the forward zigzag scan; untouched entries are 0.
    task automatic model_accept(input logic [7:0] v, input bit eob);
        logic [7:0]   m [16];
        logic [127:0] blk;
        part_q.push_back(v);
        if (eob || part_q.size() == 16) begin
            for (int p = 0; p < 16; p++) m[p] = 8'd0;
            for (int k = 0; k < part_q.size(); k++) m[zz[15 - k]] = part_q[k];
            for (int p = 0; p < 16; p++) blk[p*8 +: 8] = m[p];
            exp_q.push_back(blk);
            part_q.delete();
        end
    endtask

    task automatic step_ready();
        if (rand_ready) blk_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            step_ready();
        end
    endtask

    // Offer one coefficient until accepted (bounded wait).
    task automatic send(input logic [7:0] v, input bit eob);
        bit got;
        int waited = 0;
        coeff_valid_i = 1'b1;
        coeff_i = v;
        eob_i = eob;
        forever begin
            @(negedge clk);
            got = coeff_ready_o;
            @(posedge clk);
            if (got) model_accept(v, eob);
            #1;
            step_ready();
            if (got) break;
            waited++;
            if (waited > 300) begin
                n_vec++; n_fail++;
                $display("FAIL accept_timeout: coeff 0x%02h not accepted after %0d cycles, required acceptance", v, waited);
                break;
            end
        end
        coeff_valid_i = 1'b0;
        coeff_i = 8'($urandom());
        eob_i = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        part_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: handshake levels follow the model's count of pending blocks;
    // a presented block must match the oldest expected block every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            if (blk_valid_o !== (exp_q.size() > 0)) begin
                n_fail++;
                $display("FAIL blk_valid: got %0b, required %0b", blk_valid_o, exp_q.size() > 0);
            end
            n_vec++;
            if (coeff_ready_o !== (exp_q.size() < NBUF)) begin
                n_fail++;
                $display("FAIL coeff_ready: got %0b, required %0b", coeff_ready_o, exp_q.size() < NBUF);
            end
            if (blk_valid_o && exp_q.size() > 0) begin
                n_vec++;
                if (dut_vec !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL block_data: got %032h, required %032h", dut_vec, exp_q[0]);
                end
                if (blk_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        n_vec++;
        if (dut_vec !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %032h, required all zero", dut_vec);
        end
        @(posedge clk); #1;

        // Values 1..16, downstream stalled, block held for several cycles.
        blk_ready_i = 1'b0;
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        idle(6);
        blk_ready_i = 1'b1;
        idle(2);
        blk_ready_i = 1'b0;

        // Short eob block, then a single-coefficient eob block.
        send(8'h05, 1'b0);
        send(8'hFB, 1'b0);
        send(8'h7F, 1'b1);
        idle(2);
        blk_ready_i = 1'b1; idle(1); blk_ready_i = 1'b0;
        send(8'h42, 1'b1);

        // Coefficient held valid while a block is presented, released by a pulse.
        fork
            send(8'h99, 1'b0);
            begin
                idle(4);
                blk_ready_i = 1'b1; idle(1); blk_ready_i = 1'b0;
            end
        join
        for (int i = 0; i < 6; i++) send(8'($urandom()), 1'b0);

        // Reset mid-fill, then a full block of 0x11.
        do_reset();
        blk_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h11, 1'b0);
        idle(2);

        // 48 back-to-back coefficients with downstream always ready.
        for (int i = 0; i < 48; i++) send(8'($urandom()), 1'b0);
        idle(3);

        // Randomized traffic: random data, eob, gaps and downstream ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom()), ($urandom_range(0, 7) == 0));
        end
        send(8'($urandom()), 1'b1);
        rand_ready = 1'b0;

        // Drain with a bounded wait.
        blk_ready_i = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            idle(1);
            budget++;
        end
        idle(2);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d blocks still pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
